pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the adders library. Operands are split into lookahead groups of `group_width` bits, with one register stage per group. The group carry is forwarded stage to stage, so the block sustains one operation per clock. A valid/ready handshake on both sides gives full backpressure. Outputs are carry-out, signed overflow and zero flags, for use in datapaths where a single-cycle wide lookahead adder would miss timing.

## Interface
- `data_width`, 16: operand and result width. Must be a multiple of `group_width`; otherwise elaboration fails.
- `group_width`, 4: bits per lookahead group. Pipeline depth is G = data_width/group_width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: operands and mode are valid this cycle.
- `in_ready`  out  1: block accepts a transaction this cycle.
- `a`  in  data_width: operand A.
- `b`  in  data_width: operand B.
- `cin`  in  1: carry-in. Ignored when `sub`=1.
- `sub`  in  1: 1 selects a − b, implemented as a + ~b + 1.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `sum`  out  data_width: result.
- `cout`  out  1: carry out of the MSB. For `sub`=1, cout=1 means no borrow.
- `overflow`  out  1: signed two's-complement overflow.
- `zero`  out  1: sum == 0.

## Operation
- Acceptance happens when in_valid && in_ready at a rising edge.
- On acceptance, the effective operand is b_eff = sub ? ~b : b, and the effective carry-in is c_eff = sub ? 1 : cin.
- Stage k (k = 1..G) evaluates group k−1:
  - generate = a&b_eff and propagate = a^b_eff over the group bits.
  - Each internal carry uses the full lookahead equation from the group carry-in.
  - Stage k registers that group's sum bits, the group carry-out, the still-unprocessed operand bits, the accumulated lower sum bits and a valid bit.
- Stage 1 takes c_eff as its group carry-in. Stage k takes the stage k−1 registered carry.
- overflow = carry into MSB XOR carry out of MSB. It is computed in stage G.
- zero is the registered NOR of the full sum. It is formed in stage G from the accumulated bits.
- Stall rule: advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance=0, every stage register, including its valid bit, holds.
- Bubbles are not compressed. An empty stage still occupies its slot.
- When in_valid=0 and advance=1, a bubble (valid=0) enters stage 1.
- Results leave in acceptance order. No transaction is dropped or duplicated.

## Timing
- Latency: a transaction accepted at the end of cycle n appears with out_valid=1 in cycle n+G, provided there is no stall. G=1 gives a registered single-stage adder.
- Each stall cycle (out_valid && !out_ready) adds one cycle to the latency of every in-flight transaction.
- Throughput: 1 per cycle while out_ready=1.
- out_valid and data outputs come directly from stage G registers. They stay stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready. There is no other combinational input-to-output path.
- Reset, in the cycle after `rst` is sampled high:
  - all stage valid bits are 0, so out_valid=0;
  - sum=0, cout=0, overflow=0, zero=0;
  - in_ready=1.
- `rst` has priority over a simultaneous acceptance. That transaction is discarded.
- Reset mid-operation flushes all in-flight transactions with no output.
- Wrap-around: the sum is modulo 2^data_width. The carry is reported only on cout.

## Structure
- Package `cla_pkg` holds:
  - function num_groups(data_width, group_width);
  - the elaboration-time check that data_width % group_width == 0;
  - a typedef for the per-stage payload struct (valid, carry, partial sum, remaining a, remaining b_eff).
- Sub-module `cla_group` #(group_width) is purely combinational and is instantiated once per stage.
  - Inputs: a, b, cin.
  - Outputs: sum, group carry-out and the carry into the group MSB, the last used for overflow.
- The top level holds the stage registers, the stall logic and the flag generation.

## Test plan
All scenarios use data_width=16, group_width=4 (G=4).
- Add carry-out: 0xFFFF + 0x0001, cin=0, accepted cycle n -> cycle n+4: sum=0x0000, cout=1, overflow=0, zero=1.
- Subtract with borrow: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0, zero=0.
- Signed overflow: 0x7FFF + 0x0001 -> sum=0x8000, overflow=1, cout=0. Also sub=1, 0x8000 − 0x0001 -> sum=0x7FFF, overflow=1, cout=1.
- Backpressure: 8 back-to-back transactions with out_ready=0 for 3 cycles once out_valid rises:
  - in_ready=0 for exactly those 3 cycles;
  - the output holds the first result;
  - all 8 results appear in order, none lost or duplicated.
- Reset mid-flight: `rst` pulsed with 3 transactions in flight -> next cycle out_valid=0, sum=0, in_ready=1; no stale result ever emerges.
- Random: 10k transactions with random in_valid, out_ready, sub and cin -> every result equals the (a ± b + cin) reference in sum, cout, overflow and zero; also repeated at G=1 (group_width=16).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Stage payloads use a fixed maximum width so one typedef serves every parameterisation.
package cla_pkg;

  localparam int unsigned max_width = 64;

  function automatic int unsigned num_groups(input int unsigned data_width,
                                             input int unsigned group_width);
    return data_width / group_width;
  endfunction

  // Elaboration-time legality test used by the top level.
  function automatic bit widths_ok(input int unsigned data_width,
                                   input int unsigned group_width);
    return (group_width != 0) && (data_width % group_width == 0) &&
           (data_width <= max_width);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [max_width-1:0] psum;
    logic [max_width-1:0] a_rem;
    logic [max_width-1:0] b_rem;
  } stage_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
interface pipelined_cla_adder_if #(parameter int unsigned data_width = 16);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] a;
  logic [data_width-1:0] b;
  logic                  cin;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] sum;
  logic                  cout;
  logic                  overflow;
  logic                  zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/cla_group.sv
// Combinational lookahead group: every internal carry is the flat
// generate/propagate sum-of-products from the group carry-in.
module cla_group #(
  parameter int unsigned group_width = 4
) (
  input  logic [group_width-1:0] a,
  input  logic [group_width-1:0] b,
  input  logic                   cin,
  output logic [group_width-1:0] sum,
  output logic                   cout,
  output logic                   c_msb
);

  logic [group_width-1:0] g;
  logic [group_width-1:0] p;
  logic [group_width:0]   c;

  // NOTE: every variable gets a default first so no path through this block can infer a latch.
  always_comb begin
    logic term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= group_width; i++) begin
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
      term = cin;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = c[i] | term;
    end
  end

  assign sum   = p ^ c[group_width-1:0];
  assign cout  = c[group_width];
  assign c_msb = c[group_width-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one register stage per group,
// group carry forwarded stage to stage, whole pipe stalls on backpressure.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned data_width  = 16,
  parameter int unsigned group_width = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int unsigned G = num_groups(data_width, group_width);

  if (!widths_ok(data_width, group_width)) begin : g_width_check
    $error("data_width must be a non-zero multiple of group_width and fit max_width");
  end

  stage_t s_in;
  stage_t nxt     [G];
  stage_t stage_q [G];
  logic   advance;
  logic   msb_cin;
  logic   ovf_q;
  logic   zero_q;

  assign advance      = !stage_q[G-1].valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction folds into addition as a + ~b + 1.
  always_comb begin
    s_in       = '0;
    s_in.valid = bus.in_valid;
    s_in.carry = bus.sub ? 1'b1 : bus.cin;
    s_in.a_rem = max_width'(bus.a);
    s_in.b_rem = max_width'(bus.sub ? ~bus.b : bus.b);
  end

  for (genvar k = 0; k < G; k++) begin : g_stage
    stage_t                 prev;
    logic [group_width-1:0] gsum;
    logic                   gcout;
    logic                   gcmsb;

    if (k == 0) begin : g_first
      assign prev = s_in;
    end else begin : g_next
      assign prev = stage_q[k-1];
    end

    cla_group #(.group_width(group_width)) u_group (
      .a     (prev.a_rem[group_width-1:0]),
      .b     (prev.b_rem[group_width-1:0]),
      .cin   (prev.carry),
      .sum   (gsum),
      .cout  (gcout),
      .c_msb (gcmsb)
    );

    assign nxt[k] = '{
      valid: prev.valid,
      carry: gcout,
      psum:  prev.psum | (max_width'(gsum) << (k * group_width)),
      a_rem: prev.a_rem >> group_width,
      b_rem: prev.b_rem >> group_width
    };

    if (k == G - 1) begin : g_last
      assign msb_cin = gcmsb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
  // NOTE: the data fields are reset as well as the valid bits, because the outputs must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < G; i++) stage_q[i] <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < G; i++) stage_q[i] <= nxt[i];
      ovf_q  <= nxt[G-1].carry ^ msb_cin;
      zero_q <= ~|nxt[G-1].psum[data_width-1:0];
    end
  end

  assign bus.out_valid = stage_q[G-1].valid;
  assign bus.sum       = stage_q[G-1].psum[data_width-1:0];
  assign bus.cout      = stage_q[G-1].carry;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at G=4 and G=1, checked against an
// arithmetic reference built from unsigned/signed integer sums.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.data_width(16)) bus4 ();
  pipelined_cla_adder_if #(.data_width(16)) bus1 ();

  pipelined_cla_adder #(.data_width(16), .group_width(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  pipelined_cla_adder #(.data_width(16), .group_width(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  res_t q4[$];
  res_t q1[$];
  int acc4 = 0, acc1 = 0, got4 = 0, got1 = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   ua, ub, full, sa, sb, exact;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      full   = ua - ub;
      r.cout = (ua >= ub);
      exact  = sa - sb;
    end else begin
      full   = ua + ub + int'(cin);
      r.cout = (full > 65535);
      exact  = sa + sb + int'(cin);
    end
    r.sum  = full[15:0];
    r.ovf  = (exact > 32767) || (exact < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t got, input res_t exp);
    check({tag, "_sum"},  32'(got.sum),  32'(exp.sum));
    check({tag, "_cout"}, 32'(got.cout), 32'(exp.cout));
    check({tag, "_ovf"},  32'(got.ovf),  32'(exp.ovf));
    check({tag, "_zero"}, 32'(got.zero), 32'(exp.zero));
  endtask

  // Acceptance side: push the reference result of every accepted transaction.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      q1.delete();
    end else begin
      if (bus4.in_valid && bus4.in_ready) begin
        q4.push_back(model(bus4.a, bus4.b, bus4.cin, bus4.sub));
        acc4++;
      end
      if (bus1.in_valid && bus1.in_ready) begin
        q1.push_back(model(bus1.a, bus1.b, bus1.cin, bus1.sub));
        acc1++;
      end
    end
  end

  // Output side: pop and compare on every completed output transfer.
  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      got4++;
      if (q4.size() == 0) check("g4_unexpected_output", 32'd1, 32'd0);
      else check_res("g4", '{bus4.sum, bus4.cout, bus4.overflow, bus4.zero}, q4.pop_front());
    end
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      got1++;
      if (q1.size() == 0) check("g1_unexpected_output", 32'd1, 32'd0);
      else check_res("g1", '{bus1.sum, bus1.cout, bus1.overflow, bus1.zero}, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
  endtask

  // One isolated transaction on the G=4 instance with latency and flag checks.
  task automatic single(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input res_t exp);
    int lat;
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
    tick();
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check_res(name, '{bus4.sum, bus4.cout, bus4.overflow, bus4.zero}, exp);
    tick();
  endtask

  logic [15:0] ta [8];
  logic [15:0] tb_ [8];

  initial begin
    int   sent, stall_left, n_low, start_got, stale;
    res_t first_exp;

    idle_all();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_out_valid", 32'(bus4.out_valid), 32'd0);
    check("reset_sum",       32'(bus4.sum),       32'd0);
    check("reset_flags",     {29'd0, bus4.cout, bus4.overflow, bus4.zero}, 32'd0);
    check("reset_in_ready",  32'(bus4.in_ready),  32'd1);
    check("reset_out_valid_g1", 32'(bus1.out_valid), 32'd0);

    // Directed arithmetic corners.
    single("add_carry_out",  16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
    single("sub_borrow",     16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
    single("add_overflow",   16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
    single("sub_overflow",   16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
    single("add_cin",        16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0, 1'b0});

    // Backpressure: 8 back-to-back, out_ready low for 3 cycles once out_valid rises.
    for (int i = 0; i < 8; i++) begin
      ta[i]  = 16'($urandom);
      tb_[i] = 16'($urandom);
    end
    first_exp = model(ta[0], tb_[0], 1'b0, 1'b0);
    sent = 0; stall_left = -1; n_low = 0; start_got = got4;
    for (int c = 0; c < 60 && (got4 - start_got) < 8; c++) begin
      bus4.in_valid = (sent < 8);
      bus4.a   = ta[sent % 8];
      bus4.b   = tb_[sent % 8];
      bus4.cin = 1'b0;
      bus4.sub = 1'b0;
      if (bus4.out_valid && stall_left < 0) stall_left = 3;
      bus4.out_ready = !(stall_left > 0);
      @(negedge clk);
      if (!bus4.in_ready) n_low++;
      if (stall_left > 0) begin
        check("bp_hold_sum", 32'(bus4.sum), 32'(first_exp.sum));
        stall_left--;
      end
      if (bus4.in_valid && bus4.in_ready) sent++;
      tick();
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    check("bp_in_ready_low_cycles", 32'(n_low), 32'd3);
    check("bp_result_count", 32'(got4 - start_got), 32'd8);

    // Reset with three transactions in flight; a fourth offered during reset is discarded.
    for (int i = 0; i < 3; i++) begin
      bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    check("rst_mid_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_mid_sum",       32'(bus4.sum),       32'd0);
    check("rst_mid_in_ready",  32'(bus4.in_ready),  32'd1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.out_valid) stale++;
      tick();
    end
    check("rst_mid_no_stale", 32'(stale), 32'd0);

    // Random traffic on both instances.
    acc4 = 0; acc1 = 0; got4 = 0; got1 = 0;
    for (int c = 0; c < 60000 && (acc4 < 10000 || acc1 < 10000); c++) begin
      bus4.in_valid  = (acc4 < 10000) && ($urandom_range(0, 3) != 0);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus4.a   = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      bus4.b   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      bus4.cin = 1'($urandom);
      bus4.sub = 1'($urandom);
      bus1.in_valid  = (acc1 < 10000) && ($urandom_range(0, 3) != 0);
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      bus1.a   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      bus1.b   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      bus1.cin = 1'($urandom);
      bus1.sub = 1'($urandom);
      tick();
    end
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("rand_g4_accepted",  32'(acc4), 32'd10000);
    check("rand_g1_accepted",  32'(acc1), 32'd10000);
    check("rand_g4_delivered", 32'(got4), 32'(acc4));
    check("rand_g1_delivered", 32'(got1), 32'(acc1));
    check("rand_g4_queue_empty", 32'(q4.size()), 32'd0);
    check("rand_g1_queue_empty", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
